// File: rtl/op_fetch_if.sv
// ----------------------------------------------------------------------------
// op_fetch_if
// Bundles the signals around the op fetch sequencer: the loader byte stream,
// the run/stop controls, the op RAM port and the decode handshake.
//   master : the sequencer (op_fetch). It drives load_ready, load_err, write,
//            writeop, addr, instr, instr_pc, instr_valid and halted.
//   slave  : the surroundings (loader, op RAM, decoder). They drive the rest.
// ----------------------------------------------------------------------------
interface op_fetch_if #(
    parameter int ADDR_W = 8
);
    // Loader side
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;
    logic              load_err;
    // Run control
    logic              run_start;
    logic              stop;
    // Op RAM port
    logic              write;
    logic [7:0]        writeop;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        op;
    // Decode handshake
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              halted;

    modport master (
        input  load_start, load_valid, load_byte, load_last,
        input  run_start, stop, op, instr_ready, jump, jump_addr,
        output load_ready, load_err, write, writeop, addr,
        output instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output load_start, load_valid, load_byte, load_last,
        output run_start, stop, op, instr_ready, jump, jump_addr,
        input  load_ready, load_err, write, writeop, addr,
        input  instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/op_fetch.sv
// ----------------------------------------------------------------------------
// op_fetch
// Owns the op RAM port. In LOAD it writes a program byte stream into the RAM
// from address 0 upwards; in ISSUE/WAIT/PRESENT it reads one op at a time and
// offers it to decode over a valid/ready handshake, following jumps, until
// decode accepts HALT_OP.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active-low
//   bus (master)   load_*        : program byte stream in, load_ready/load_err out
//                  run_start/stop: start fetching at START_PC / abort to IDLE
//                  write/writeop/addr/op : op RAM port (outputs registered)
//                  instr/instr_pc/instr_valid/instr_ready/jump/jump_addr : decode
//                  halted        : high while in HALT
// Timing: addr is loaded as the FSM enters ISSUE, so the RAM sees it during the
// ISSUE cycle; op is captured after READ_LAT WAIT cycles. With instr_ready held
// high one instr is delivered every READ_LAT+2 cycles.
// ----------------------------------------------------------------------------
module op_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                READ_LAT = 1,        // 1 or 2
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter logic [7:0]        HALT_OP  = 8'hFF
) (
    input  logic    clk,
    input  logic    rst,
    op_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_PRESENT, S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, next_state;
    logic [ADDR_W-1:0] pc, next_pc;
    logic [ADDR_W-1:0] load_addr;
    logic [1:0]        lat_cnt;
    logic              lat_done;
    logic              load_acc;
    logic              accept;

    // ---------------- state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // ---------------- outputs / handshake decode ----------------
    always_comb begin
        // A byte presented alongside stop is not taken.
        bus.load_ready = (state == S_LOAD) && !bus.stop;
        bus.halted     = (state == S_HALT);
        load_acc       = bus.load_ready && bus.load_valid;
        accept         = (state == S_PRESENT) && bus.instr_valid && bus.instr_ready;
        lat_done       = (lat_cnt == 2'(READ_LAT - 1));
    end

    // ---------------- next state ----------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        case (state)
            S_IDLE: begin
                if (bus.load_start) begin
                    next_state = S_LOAD;
                end else if (bus.run_start) begin
                    next_state = S_ISSUE;
                    next_pc    = START_PC;
                end
            end
            S_LOAD: begin
                // Leave after the last byte, or after the byte that fills the RAM.
                if (bus.stop)
                    next_state = S_IDLE;
                else if (load_acc && (bus.load_last || load_addr == LAST_ADDR))
                    next_state = S_IDLE;
            end
            S_ISSUE: begin
                next_state = bus.stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.stop)      next_state = S_IDLE;
                else if (lat_done) next_state = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.stop) begin
                    next_state = S_IDLE;
                end else if (accept) begin
                    if (bus.instr == HALT_OP) begin
                        next_state = S_HALT;
                    end else begin
                        next_state = S_ISSUE;
                        next_pc    = bus.jump ? bus.jump_addr : pc + ADDR_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (bus.load_start) begin
                    next_state = S_LOAD;
                end else if (bus.stop) begin
                    next_state = S_IDLE;
                end else if (bus.run_start) begin
                    next_state = S_ISSUE;
                    next_pc    = START_PC;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.write       <= 1'b0;
            bus.writeop     <= '0;
            bus.addr        <= '0;
            bus.load_err    <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
            pc              <= '0;
            load_addr       <= '0;
            lat_cnt         <= '0;
        end else begin
            // write is a one-cycle echo of a load accept.
            bus.write <= load_acc;
            if (load_acc) begin
                bus.writeop <= bus.load_byte;
                bus.addr    <= load_addr;
                load_addr   <= load_addr + ADDR_W'(1);
                if (!bus.load_last && load_addr == LAST_ADDR)
                    bus.load_err <= 1'b1;
            end

            if (next_state == S_LOAD && state != S_LOAD) begin
                load_addr    <= '0;
                bus.load_err <= 1'b0;
            end

            // ISSUE never repeats, so this fires exactly once per fetch.
            if (next_state == S_ISSUE) begin
                pc       <= next_pc;
                bus.addr <= next_pc;
            end

            lat_cnt <= (state == S_WAIT) ? lat_cnt + 2'd1 : 2'd0;

            if (state == S_WAIT && next_state == S_PRESENT) begin
                bus.instr       <= bus.op;
                bus.instr_pc    <= pc;
                bus.instr_valid <= 1'b1;
            end else if (next_state != S_PRESENT) begin
                bus.instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_op_fetch.sv
// ----------------------------------------------------------------------------
// tb_op_fetch
// Drives op_fetch through op_fetch_if with a behavioural op RAM. Expected
// writes, instr/instr_pc sequences, halting and error flags come from a
// program-level model: a copy of the program bytes plus a pc walked by the
// load/jump/halt rules.
// ----------------------------------------------------------------------------
module tb_op_fetch;
    localparam int         ADDR_W   = 8;
    localparam int         READ_LAT = 1;
    localparam logic [7:0] START_PC = 8'h00;
    localparam logic [7:0] HALT_OP  = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    op_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    op_fetch #(
        .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .START_PC(START_PC), .HALT_OP(HALT_OP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] ram       [256];   // the op RAM itself, written only by the DUT
    logic [7:0] ram_model [256];   // what the program says the RAM should hold
    logic [7:0] prog      [256];
    int         js_idx [$];        // accept index -> forced jump
    logic [7:0] js_addr[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         wr_count = 0;

    always @(posedge clk) begin
        if (bus.write === 1'b1) ram[bus.addr] <= bus.writeop;
        bus.op <= ram[bus.addr];
    end

    always @(negedge clk) if (bus.write === 1'b1) wr_count++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Loads prog[0..n-1]; load_last on byte n-1 when with_last.
    task automatic load_prog(input int n, input bit with_last, input int gap_pct);
        logic [7:0] la, prev_addr, prev_byte;
        bit prev_acc, acc, done, exp_err, v;
        int i, wr_before, n_acc;
        la = 8'h00; prev_addr = 8'h00; prev_byte = 8'h00;
        prev_acc = 0; done = 0; exp_err = 0; i = 0; n_acc = 0;
        wr_before = wr_count;
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.load_valid = v;
            bus.load_byte  = prog[i];
            bus.load_last  = with_last && (i == n - 1);
            @(negedge clk);
            n_checks++; if (bus.write !== prev_acc) begin n_fail++; $display("FAIL load write strobe: got %0b want %0b", bus.write, prev_acc); end
            if (prev_acc) begin
                n_checks++; if (bus.addr !== prev_addr) begin n_fail++; $display("FAIL load addr: got %0h want %0h", bus.addr, prev_addr); end
                n_checks++; if (bus.writeop !== prev_byte) begin n_fail++; $display("FAIL load writeop: got %0h want %0h", bus.writeop, prev_byte); end
            end
            n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready in LOAD: got %0b want 1", bus.load_ready); end
            acc = v && (bus.load_ready === 1'b1);
            if (acc) begin
                prev_addr = la; prev_byte = prog[i]; la = la + 8'd1; n_acc++;
                if (with_last && i == n - 1) done = 1;
                else if (i == 255) begin exp_err = 1; done = 1; end
                i++;
            end
            prev_acc = acc;
            tick();
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        if (!done) begin n_checks++; n_fail++; $display("FAIL load timeout: got %0d accepts want %0d", n_acc, n); end
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b1) begin n_fail++; $display("FAIL final write: got %0b want 1", bus.write); end
        n_checks++; if (bus.addr !== prev_addr) begin n_fail++; $display("FAIL final addr: got %0h want %0h", bus.addr, prev_addr); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL idle after load: load_ready %0b want 0", bus.load_ready); end
        n_checks++; if (bus.load_err !== exp_err) begin n_fail++; $display("FAIL load_err: got %0b want %0b", bus.load_err, exp_err); end
        tick();
        n_checks++; if (wr_count - wr_before !== n_acc) begin n_fail++; $display("FAIL write count: got %0d want %0d", wr_count - wr_before, n_acc); end
        for (int k = 0; k < n && k < 256; k++) ram_model[k] = prog[k];
    endtask

    // Runs from run_start until halt or max_acc accepts, checking each accepted
    // instr against the program model.
    task automatic fetch_run(input int max_acc, input int ready_pct, input int jump_pct,
                             input logic [7:0] stall_pc, input int stall_len);
        logic [7:0] m_pc, ja, s_instr, s_pc, s_addr;
        int acc, last_acc, stall_left, budget;
        bit stalled, halt_exp, done, rdy, jmp;
        m_pc = START_PC; acc = 0; last_acc = 0; stall_left = stall_len;
        stalled = 0; halt_exp = 0; done = 0;
        s_instr = 8'h00; s_pc = 8'h00; s_addr = 8'h00;
        budget = max_acc * 20 + 50;
        bus.run_start = 1'b1; tick(); bus.run_start = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            rdy = ($urandom_range(99) < ready_pct);
            if (bus.instr_valid === 1'b1 && bus.instr_pc === stall_pc && stall_left > 0) begin
                rdy = 0; stall_left--;
            end
            jmp = (jump_pct > 0) && ($urandom_range(99) < jump_pct);
            ja  = 8'($urandom_range(255));
            foreach (js_idx[k]) if (js_idx[k] == acc) begin jmp = 1; ja = js_addr[k]; end
            bus.instr_ready = rdy; bus.jump = jmp; bus.jump_addr = ja;
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin
                if (stalled) begin
                    n_checks++; if (bus.instr !== s_instr) begin n_fail++; $display("FAIL stall instr: got %0h want %0h", bus.instr, s_instr); end
                    n_checks++; if (bus.instr_pc !== s_pc) begin n_fail++; $display("FAIL stall instr_pc: got %0h want %0h", bus.instr_pc, s_pc); end
                    n_checks++; if (bus.addr !== s_addr) begin n_fail++; $display("FAIL stall addr: got %0h want %0h", bus.addr, s_addr); end
                end
                if (rdy) begin
                    n_checks++; if (bus.instr !== ram_model[m_pc]) begin n_fail++; $display("FAIL instr: got %0h want %0h", bus.instr, ram_model[m_pc]); end
                    n_checks++; if (bus.instr_pc !== m_pc) begin n_fail++; $display("FAIL instr_pc: got %0h want %0h", bus.instr_pc, m_pc); end
                    if (ready_pct == 100 && stall_len == 0 && acc > 0) begin
                        n_checks++; if (c - last_acc != READ_LAT + 2) begin n_fail++; $display("FAIL throughput: got %0d cycles want %0d", c - last_acc, READ_LAT + 2); end
                    end
                    last_acc = c; acc++; stalled = 0;
                    if (ram_model[m_pc] == HALT_OP) halt_exp = 1;
                    else m_pc = jmp ? ja : m_pc + 8'd1;
                    if (halt_exp || acc == max_acc) done = 1;
                end else begin
                    stalled = 1; s_instr = bus.instr; s_pc = bus.instr_pc; s_addr = bus.addr;
                end
            end else begin
                stalled = 0;
            end
            tick();
        end
        bus.instr_ready = 1'b0; bus.jump = 1'b0;
        if (!done) begin n_checks++; n_fail++; $display("FAIL fetch timeout: got %0d accepts want %0d", acc, max_acc); end
        if (stall_len > 0) begin
            n_checks++; if (stall_left != 0) begin n_fail++; $display("FAIL stall never seen: got %0d left want 0", stall_left); end
        end
        if (halt_exp) begin
            @(negedge clk);
            n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halted: got %0b want 1", bus.halted); end
            n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL valid in HALT: got %0b want 0", bus.instr_valid); end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        @(negedge clk);
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL reset load_ready: got %0b want 0", bus.load_ready); end
        n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL reset load_err: got %0b want 0", bus.load_err); end
        n_checks++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset write: got %0b want 0", bus.write); end
        n_checks++; if (bus.writeop !== 8'h00) begin n_fail++; $display("FAIL reset writeop: got %0h want 0", bus.writeop); end
        n_checks++; if (bus.addr !== 8'h00) begin n_fail++; $display("FAIL reset addr: got %0h want 0", bus.addr); end
        n_checks++; if (bus.instr !== 8'h00) begin n_fail++; $display("FAIL reset instr: got %0h want 0", bus.instr); end
        n_checks++; if (bus.instr_pc !== 8'h00) begin n_fail++; $display("FAIL reset instr_pc: got %0h want 0", bus.instr_pc); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset instr_valid: got %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset halted: got %0b want 0", bus.halted); end
        rst = 1'b1; tick();
    endtask

    task automatic test_load_small();
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        load_prog(3, 1'b1, 30);
    endtask

    task automatic test_load_overflow();
        for (int k = 0; k < 256; k++) prog[k] = 8'($urandom_range(255));
        load_prog(256, 1'b0, 10);
    endtask

    task automatic test_run_basic();
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'hFF;
        load_prog(3, 1'b1, 0);
        js_idx.delete(); js_addr.delete();
        fetch_run(10, 100, 0, 8'h00, 0);
    endtask

    task automatic test_stall();
        // Restart from HALT with decode holding off on the op at pc 1.
        fetch_run(10, 100, 0, 8'h01, 5);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL stop from HALT: halted %0b want 0", bus.halted); end
        tick();
    endtask

    task automatic test_jump();
        for (int k = 0; k < 256; k++) prog[k] = 8'(k) ^ 8'h5A;
        prog[8'hA5] = 8'h00;
        prog[8'hF2] = HALT_OP;
        load_prog(256, 1'b1, 0);
        // pc 0,1,2,3 -> F0,F1 -> FF -> 00 (wrap) -> F2 (halt)
        js_idx  = '{3, 5, 7};
        js_addr = '{8'hF0, 8'hFF, 8'hF2};
        fetch_run(20, 100, 0, 8'h00, 0);
        js_idx.delete(); js_addr.delete();
    endtask

    task automatic test_stop_wait();
        bus.run_start = 1'b1; tick(); bus.run_start = 1'b0;   // now ISSUE
        tick();                                             // now WAIT
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stop in WAIT valid: got %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL stop in WAIT write: got %0b want 0", bus.write); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL stop in WAIT halted: got %0b want 0", bus.halted); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL discarded op shown: valid %0b want 0", bus.instr_valid); end
        end
        tick();
    endtask

    task automatic test_rst_load();
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        bus.load_valid = 1'b1; bus.load_byte = 8'hAA; bus.load_last = 1'b0;
        tick();
        bus.load_byte = 8'hBB;
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b1) begin n_fail++; $display("FAIL pre-reset write: got %0b want 1", bus.write); end
        rst = 1'b0;
        tick();
        bus.load_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL write in reset: got %0b want 0", bus.write); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready in reset: got %0b want 0", bus.load_ready); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL valid in reset: got %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.addr !== 8'h00) begin n_fail++; $display("FAIL addr in reset: got %0h want 0", bus.addr); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL idle after reset: load_ready %0b want 0", bus.load_ready); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 256; k++) prog[k] = 8'($urandom_range(255));
        load_prog(256, 1'b1, 20);
        fetch_run(30, 60, 25, 8'h00, 0);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stop after random: valid %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL stop after random: halted %0b want 0", bus.halted); end
        tick();
    endtask

    initial begin
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_byte = 8'h00; bus.load_last = 1'b0;
        bus.run_start = 1'b0; bus.stop = 1'b0; bus.instr_ready = 1'b0;
        bus.jump = 1'b0; bus.jump_addr = 8'h00;
        test_reset();
        test_load_small();
        test_load_overflow();
        test_run_basic();
        test_stall();
        test_jump();
        test_stop_wait();
        test_rst_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
